// File: rtl/icache_line_fill.sv
// AXI4 read master that refills one instruction-cache line with a single INCR burst
// and writes each returned word into the cache data array.
module icache_line_fill #(
    parameter int LINE_WORDS = 4,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          miss_valid,
    output logic                          miss_ready,
    input  logic [ADDR_WIDTH-1:0]         miss_addr,
    output logic                          fill_we,
    output logic [$clog2(LINE_WORDS)-1:0] fill_word_idx,
    output logic [31:0]                   fill_data,
    output logic                          fill_done,
    output logic                          fill_err,
    output logic                          axi_arid,
    output logic [ADDR_WIDTH-1:0]         axi_araddr,
    output logic [7:0]                    axi_arlen,
    output logic [2:0]                    axi_arsize,
    output logic [1:0]                    axi_arburst,
    output logic                          axi_arvalid,
    input  logic                          axi_arready,
    input  logic                          axi_rid,
    input  logic [31:0]                   axi_rdata,
    input  logic [1:0]                    axi_rresp,
    input  logic                          axi_rlast,
    input  logic                          axi_rvalid,
    output logic                          axi_rready
);

    localparam int IDX_W = $clog2(LINE_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(LINE_WORDS * 4 - 1);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

    state_t                  state, state_d;
    logic [IDX_W-1:0]        beat_cnt, beat_cnt_d;
    logic                    err, err_d;
    logic                    miss_ready_d, arvalid_d, rready_d;
    logic [ADDR_WIDTH-1:0]   araddr_d;
    logic                    fill_we_d, fill_done_d, fill_err_d;
    logic [IDX_W-1:0]        fill_word_idx_d;
    logic [31:0]             fill_data_d;

    logic                    beat, beat_err, last_beat, req_acc, ar_acc;
    logic [ADDR_WIDTH-1:0]   line_addr;
    logic                    unused_rid;

    assign axi_arid    = 1'b0;
    assign axi_arlen   = 8'(LINE_WORDS - 1);
    assign axi_arsize  = 3'b010;
    assign axi_arburst = 2'b01;
    assign unused_rid  = axi_rid;

    assign line_addr = miss_addr & ~OFF_MASK;
    assign req_acc   = miss_valid && miss_ready;
    assign ar_acc    = axi_arvalid && axi_arready;
    assign beat      = axi_rvalid && axi_rready;
    // Framing is checked against the beat count; rlast never ends the burst.
    assign beat_err  = (axi_rresp != 2'b00) || (axi_rlast != (beat_cnt == LAST_IDX));
    assign last_beat = beat && (beat_cnt == LAST_IDX);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            beat_cnt      <= '0;
            err           <= 1'b0;
            miss_ready    <= 1'b0;
            axi_arvalid   <= 1'b0;
            axi_araddr    <= '0;
            axi_rready    <= 1'b0;
            fill_we       <= 1'b0;
            fill_word_idx <= '0;
            fill_data     <= '0;
            fill_done     <= 1'b0;
            fill_err      <= 1'b0;
        end else begin
            state         <= state_d;
            beat_cnt      <= beat_cnt_d;
            err           <= err_d;
            miss_ready    <= miss_ready_d;
            axi_arvalid   <= arvalid_d;
            axi_araddr    <= araddr_d;
            axi_rready    <= rready_d;
            fill_we       <= fill_we_d;
            fill_word_idx <= fill_word_idx_d;
            fill_data     <= fill_data_d;
            fill_done     <= fill_done_d;
            fill_err      <= fill_err_d;
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: if (req_acc)   state_d = ADDR;
            ADDR: if (ar_acc)    state_d = DATA;
            DATA: if (last_beat) state_d = DONE;
            DONE:                state_d = IDLE;
        endcase
    end

    always_comb begin
        beat_cnt_d      = beat_cnt;
        err_d           = err;
        miss_ready_d    = miss_ready;
        arvalid_d       = axi_arvalid;
        araddr_d        = axi_araddr;
        rready_d        = axi_rready;
        fill_we_d       = 1'b0;
        fill_word_idx_d = fill_word_idx;
        fill_data_d     = fill_data;
        fill_done_d     = 1'b0;
        fill_err_d      = 1'b0;
        unique case (state)
            IDLE: begin
                miss_ready_d = 1'b1;
                if (req_acc) begin
                    miss_ready_d = 1'b0;
                    arvalid_d    = 1'b1;
                    araddr_d     = line_addr;
                end
            end
            ADDR: begin
                if (ar_acc) begin
                    arvalid_d  = 1'b0;
                    rready_d   = 1'b1;
                    beat_cnt_d = '0;
                    err_d      = 1'b0;
                end
            end
            DATA: begin
                if (beat) begin
                    fill_we_d       = 1'b1;
                    fill_word_idx_d = beat_cnt;
                    fill_data_d     = axi_rdata;
                    beat_cnt_d      = beat_cnt + 1'b1;
                    err_d           = err || beat_err;
                    if (last_beat) begin
                        rready_d    = 1'b0;
                        fill_done_d = 1'b1;
                        fill_err_d  = err || beat_err;
                    end
                end
            end
            // Raising miss_ready here lets the next request land the cycle after DONE.
            DONE: miss_ready_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_icache_line_fill.sv
// Directed bench for icache_line_fill: a cycle-stepped AXI read slave backed by a
// small ROM where word address w holds 0x60 + w.
module tb_icache_line_fill;

    localparam int LW = 4;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          miss_valid;
    logic          miss_ready;
    logic [AW-1:0] miss_addr;
    logic          fill_we;
    logic [1:0]    fill_word_idx;
    logic [31:0]   fill_data;
    logic          fill_done;
    logic          fill_err;
    logic          axi_arid;
    logic [AW-1:0] axi_araddr;
    logic [7:0]    axi_arlen;
    logic [2:0]    axi_arsize;
    logic [1:0]    axi_arburst;
    logic          axi_arvalid;
    logic          axi_arready;
    logic          axi_rid;
    logic [31:0]   axi_rdata;
    logic [1:0]    axi_rresp;
    logic          axi_rlast;
    logic          axi_rvalid;
    logic          axi_rready;

    int n_checks = 0;
    int n_fail   = 0;
    int hs_cnt   = 0;
    int we_cnt   = 0;
    int done_cnt = 0;

    icache_line_fill #(.LINE_WORDS(LW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr),
        .fill_we(fill_we), .fill_word_idx(fill_word_idx), .fill_data(fill_data),
        .fill_done(fill_done), .fill_err(fill_err),
        .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
        .axi_arsize(axi_arsize), .axi_arburst(axi_arburst),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
        .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
    );

    always #5 clk = ~clk;

    // Event counters sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (axi_arvalid && axi_arready) hs_cnt = hs_cnt + 1;
        if (fill_we)                    we_cnt = we_cnt + 1;
        if (fill_done)                  done_cnt = done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One refill; stop_beats < LW leaves the block mid-burst for the reset case.
    task automatic do_fill(input logic [31:0] addr, input logic [31:0] exp_addr,
                           input int ar_wait, input logic [15:0] vpat,
                           input int bad_beat, input int last_beat,
                           input int stop_beats, input logic exp_err);
        int          waitc;
        int          nbeat;
        int          p;
        int          cyc;
        logic        sent;
        logic [31:0] exp_data;
        waitc = 0;
        while (!miss_ready && waitc < 10) begin
            tick;
            waitc++;
        end
        check("miss_ready_before_req", 32'(miss_ready), 1);
        miss_valid = 1'b1;
        miss_addr  = addr;
        tick;
        miss_valid = 1'b0;
        miss_addr  = '0;
        check("arvalid_set", 32'(axi_arvalid), 1);
        check("araddr", axi_araddr, exp_addr);
        check("miss_ready_busy", 32'(miss_ready), 0);
        for (int i = 0; i < ar_wait; i++) begin
            axi_arready = 1'b0;
            tick;
            check("arvalid_hold", 32'(axi_arvalid), 1);
            check("araddr_hold", axi_araddr, exp_addr);
        end
        axi_arready = 1'b1;
        tick;
        axi_arready = 1'b0;
        check("arvalid_clear", 32'(axi_arvalid), 0);
        check("rready_set", 32'(axi_rready), 1);
        nbeat = 0;
        p     = 0;
        cyc   = 0;
        while (nbeat < stop_beats && cyc < 40) begin
            axi_rvalid = (p < 16) ? vpat[p] : 1'b1;
            p++;
            exp_data  = 32'h60 + (exp_addr >> 2) + 32'(nbeat);
            axi_rdata = exp_data;
            axi_rresp = (nbeat == bad_beat) ? 2'b10 : 2'b00;
            axi_rlast = (nbeat == last_beat);
            sent      = axi_rvalid && axi_rready;
            tick;
            cyc++;
            if (sent) begin
                check("fill_we", 32'(fill_we), 1);
                check("fill_idx", 32'(fill_word_idx), 32'(nbeat));
                check("fill_data", fill_data, exp_data);
                if (nbeat == LW - 1) begin
                    check("fill_done", 32'(fill_done), 1);
                    check("fill_err", 32'(fill_err), 32'(exp_err));
                    check("rready_drop", 32'(axi_rready), 0);
                end else begin
                    check("fill_done_early", 32'(fill_done), 0);
                    check("rready_hold", 32'(axi_rready), 1);
                end
                nbeat++;
            end else begin
                check("fill_we_idle", 32'(fill_we), 0);
            end
        end
        axi_rvalid = 1'b0;
        axi_rlast  = 1'b0;
        axi_rresp  = 2'b00;
        if (cyc >= 40) check("data_timeout", 32'(nbeat), 32'(stop_beats));
        if (stop_beats == LW) begin
            tick;
            check("fill_we_after_done", 32'(fill_we), 0);
            check("fill_done_pulse", 32'(fill_done), 0);
            check("miss_ready_back", 32'(miss_ready), 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b0;
        miss_valid  = 1'b0;
        miss_addr   = '0;
        axi_arready = 1'b0;
        axi_rid     = 1'b0;
        axi_rdata   = '0;
        axi_rresp   = 2'b00;
        axi_rlast   = 1'b0;
        axi_rvalid  = 1'b0;
        tick;
        tick;
        check("rst_miss_ready", 32'(miss_ready), 0);
        check("rst_fill_we", 32'(fill_we), 0);
        check("rst_fill_done", 32'(fill_done), 0);
        check("rst_fill_err", 32'(fill_err), 0);
        check("rst_arvalid", 32'(axi_arvalid), 0);
        check("rst_araddr", axi_araddr, 0);
        check("rst_rready", 32'(axi_rready), 0);
        check("arid", 32'(axi_arid), 0);
        check("arlen", 32'(axi_arlen), 3);
        check("arsize", 32'(axi_arsize), 2);
        check("arburst", 32'(axi_arburst), 1);
        rst = 1'b1;

        // Zero-wait refill of the line holding 0x104.
        do_fill(32'h104, 32'h100, 0, 16'hFFFF, -1, 3, LW, 1'b0);
        // Address phase stalled three cycles.
        do_fill(32'h10C, 32'h100, 3, 16'hFFFF, -1, 3, LW, 1'b0);
        check("ar_handshakes", 32'(hs_cnt), 2);
        // rvalid pattern 1,0,0,1,0,1,1.
        do_fill(32'h100, 32'h100, 0, 16'h0069, -1, 3, LW, 1'b0);
        // SLVERR on beat 1, then a clean line.
        do_fill(32'h13F, 32'h130, 0, 16'hFFFF, 1, 3, LW, 1'b1);
        do_fill(32'h140, 32'h140, 0, 16'hFFFF, -1, 3, LW, 1'b0);
        // Early rlast on beat 2.
        do_fill(32'h158, 32'h150, 0, 16'hFFFF, -1, 2, LW, 1'b1);
        check("done_count_mid", 32'(done_cnt), 6);
        check("we_count_mid", 32'(we_cnt), 24);

        // Reset after two beats of a burst.
        do_fill(32'h300, 32'h300, 0, 16'hFFFF, -1, 3, 2, 1'b0);
        rst        = 1'b0;
        axi_rvalid = 1'b1;
        axi_rdata  = 32'hDEAD_BEEF;
        tick;
        axi_rvalid = 1'b0;
        check("abort_miss_ready", 32'(miss_ready), 0);
        check("abort_fill_we", 32'(fill_we), 0);
        check("abort_fill_done", 32'(fill_done), 0);
        check("abort_fill_err", 32'(fill_err), 0);
        check("abort_arvalid", 32'(axi_arvalid), 0);
        check("abort_araddr", axi_araddr, 0);
        check("abort_rready", 32'(axi_rready), 0);
        check("abort_fill_data", fill_data, 0);
        check("abort_fill_idx", 32'(fill_word_idx), 0);
        rst = 1'b1;
        tick;
        check("abort_ready_back", 32'(miss_ready), 1);
        check("abort_no_done", 32'(fill_done), 0);
        do_fill(32'h200, 32'h200, 0, 16'hFFFF, -1, 3, LW, 1'b0);

        check("total_handshakes", 32'(hs_cnt), 8);
        check("total_we", 32'(we_cnt), 30);
        check("total_done", 32'(done_cnt), 7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/icache_line_fill.md
Name: icache_line_fill

Overview:
AXI4 read master that refills one instruction-cache line on a miss. It sits directly upstream of instruction_rom's read channel. It accepts a miss address from the fetch/cache controller and issues one 32-bit INCR burst covering the line. It then writes each returned word into the cache data array and reports completion with an error flag. The block is read-only; the top level ties off the AXI write channels.

Parameters:
LINE_WORDS, 4, 32-bit words per cache line; power of two, 2..16.
ADDR_WIDTH, 32, byte-address width of miss_addr and axi_araddr.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
miss_valid  in  1  refill request
miss_ready  out  1  block can accept a request
miss_addr  in  ADDR_WIDTH  byte address of the missing fetch; any alignment
fill_we  out  1  write-enable pulse toward the cache data array
fill_word_idx  out  $clog2(LINE_WORDS)  word index within the line
fill_data  out  32  word to write
fill_done  out  1  one-cycle pulse at end of refill
fill_err  out  1  valid with fill_done; 1 = bad response or framing
axi_arid  out  1  constant 0
axi_araddr  out  ADDR_WIDTH  line-aligned burst start address
axi_arlen  out  8  constant LINE_WORDS-1
axi_arsize  out  3  constant 3'b010
axi_arburst  out  2  constant 2'b01 (INCR)
axi_arvalid  out  1  address valid
axi_arready  in  1  address accepted
axi_rid  in  1  ignored
axi_rdata  in  32  read data
axi_rresp  in  2  read response
axi_rlast  in  1  last beat
axi_rvalid  in  1  data valid
axi_rready  out  1  data accept

Behaviour:
- All outputs are registered except the constants. While rst=0, every registered output is 0 and state = IDLE.
- FSM states: IDLE, ADDR, DATA, DONE.
- IDLE:
  - miss_ready <= 1.
  - On miss_valid && miss_ready: latch line_addr = miss_addr with its low $clog2(LINE_WORDS*4) bits cleared; miss_ready <= 0; axi_arvalid <= 1; axi_araddr <= line_addr; go to ADDR.
- ADDR:
  - axi_arvalid and axi_araddr stay stable until axi_arready.
  - On arvalid && arready: arvalid <= 0; axi_rready <= 1; beat_cnt <= 0; err <= 0; go to DATA.
- DATA: on each rvalid && rready beat, the next cycle drives:
  - fill_we = 1 for exactly one cycle;
  - fill_word_idx = beat_cnt;
  - fill_data = rdata of that beat.
- DATA, per-beat bookkeeping:
  - beat_cnt increments on each beat.
  - err is sticky. It is set if rresp != 2'b00, or if rlast != (beat_cnt == LINE_WORDS-1).
  - No beat occurs in cycles where rvalid=0; rvalid gaps are allowed.
- DATA, termination:
  - The burst ends by count, never by rlast.
  - The beat with beat_cnt == LINE_WORDS-1 sets rready <= 0 and moves to DONE.
- DONE: this cycle carries the last fill_we together with fill_done=1 and fill_err=err. Next state is IDLE.
- Back-to-back requests: miss_ready returns to 1 in the cycle after DONE. Minimum issue interval is therefore 3 + LINE_WORDS cycles with zero-wait slave responses.
- Erroneous beats are still written to the array. The consumer must discard the line when fill_err=1.
- Reset mid-operation: the burst is abandoned, with no fill_done and no further fill_we. The slave shares rst, so no outstanding beats survive.
- Address wrap: line_addr + 4*(LINE_WORDS-1) never crosses a line. Top-of-space lines need no special handling.

Test Plan:
1. miss_addr=0x104, LINE_WORDS=4, zero-wait ROM holding 0xA0..0xA3 at words 0x40..0x43 -> araddr=0x100, arlen=3, arsize=2, arburst=1; fill_we x4 with idx 0,1,2,3 and data 0xA0..0xA3; fill_done=1 with fill_err=0 in the same cycle as idx 3.
2. Hold arready=0 for 3 cycles -> arvalid=1 and araddr=0x100 stable for all 4 cycles; exactly one AR handshake.
3. Insert rvalid gaps (pattern 1,0,0,1,0,1,1) -> exactly 4 fill_we pulses with correct idx/data; fill_done 1 cycle after the 4th beat.
4. rresp=2'b10 on beat 1 -> all 4 words still written; fill_err=1 at fill_done. The next clean miss reports fill_err=0.
5. rlast asserted on beat 2 of 4 -> fill_err=1; the block still consumes 4 beats.
6. rst=0 while in DATA after 2 beats -> next cycle all outputs 0, no fill_done. After release, miss_ready=1 within 1 cycle and a new miss at 0x200 completes normally.
